// File: rtl/apb_ucpd_rx_sym_dec.sv
// UCPD receive 4b5b symbol decoder: hunts for K-code ordered sets, then decodes 5b symbols to bytes.
// Optional build macro UCPD_RX_KCODE_STRICT_EN: ordered sets must match on all four K-codes.
//
// state | meaning
// IDLE  | receiver disabled, nothing tracked
// HUNT  | sliding 20-bit window compared against enabled ordered sets
// SYM   | aligned; collecting 5-bit symbols into nibbles/bytes until EOP or error
module apb_ucpd_rx_sym_dec #(
    parameter int MAX_BYTES = 264
) (
    input  logic       ic_clk,
    input  logic       ic_rst_n,
    input  logic       rx_en,
    input  logic       bit_vld,
    input  logic       bit_in,
    input  logic [8:0] rx_ordset_en,
    output logic       ordset_vld,
    output logic [2:0] ordset_type,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic [9:0] rx_byte_cnt,
    output logic       eop_ok,
    output logic       sym_err,
    output logic       hrst_det,
    output logic       crst_det,
    output logic       busy
);

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

`ifdef UCPD_RX_KCODE_STRICT_EN
    localparam logic [2:0] HIT_MIN = 3'd4;
`else
    localparam logic [2:0] HIT_MIN = 3'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SYM
    } state_t;

    state_t      state;
    logic [19:0] hunt_sr;
    logic [4:0]  sym_sr;
    logic [2:0]  bit_cnt;
    logic [3:0]  nib_lo;
    logic        nib_have;

    logic [19:0] hunt_next;
    logic [4:0]  sym_next;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [4:0]  dec;
    logic        ordset_en_unused;

    assign ordset_en_unused = ^rx_ordset_en[8:7];

    // First received symbol sits in the low 5 bits, so patterns are packed last-symbol-first.
    function automatic logic [19:0] os_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    os_pat = {K_S2, K_S1, K_S1, K_S1};
            3'd1:    os_pat = {K_S3, K_S3, K_S1, K_S1};
            3'd2:    os_pat = {K_S3, K_S1, K_S3, K_S1};
            3'd3:    os_pat = {K_R2, K_R1, K_R1, K_R1};
            3'd4:    os_pat = {K_S3, K_R1, K_S1, K_R1};
            3'd5:    os_pat = {K_S3, K_R2, K_R2, K_S1};
            3'd6:    os_pat = {K_S2, K_S3, K_R2, K_S1};
            default: os_pat = 20'd0;
        endcase
    endfunction

    function automatic logic [2:0] sym_hits(input logic [19:0] a, input logic [19:0] b);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (a[5*k +: 5] == b[5*k +: 5]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Returns {valid, nibble}; valid=0 for K-codes and unused codes.
    function automatic logic [4:0] dec_data(input logic [4:0] s);
        case (s)
            5'b11110: dec_data = {1'b1, 4'h0};
            5'b01001: dec_data = {1'b1, 4'h1};
            5'b10100: dec_data = {1'b1, 4'h2};
            5'b10101: dec_data = {1'b1, 4'h3};
            5'b01010: dec_data = {1'b1, 4'h4};
            5'b01011: dec_data = {1'b1, 4'h5};
            5'b01110: dec_data = {1'b1, 4'h6};
            5'b01111: dec_data = {1'b1, 4'h7};
            5'b10010: dec_data = {1'b1, 4'h8};
            5'b10011: dec_data = {1'b1, 4'h9};
            5'b10110: dec_data = {1'b1, 4'hA};
            5'b10111: dec_data = {1'b1, 4'hB};
            5'b11010: dec_data = {1'b1, 4'hC};
            5'b11011: dec_data = {1'b1, 4'hD};
            5'b11100: dec_data = {1'b1, 4'hE};
            5'b11101: dec_data = {1'b1, 4'hF};
            default:  dec_data = 5'd0;
        endcase
    endfunction

    assign hunt_next = {bit_in, hunt_sr[19:1]};
    assign sym_next  = {bit_in, sym_sr[4:1]};
    assign dec       = dec_data(sym_next);

    // Descending scan so the lowest enabled index wins on multiple matches.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (rx_ordset_en[i] && (sym_hits(hunt_next, os_pat(3'(i))) >= HIT_MIN)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state       <= ST_IDLE;
            hunt_sr     <= 20'd0;
            sym_sr      <= 5'd0;
            bit_cnt     <= 3'd0;
            nib_lo      <= 4'd0;
            nib_have    <= 1'b0;
            ordset_vld  <= 1'b0;
            ordset_type <= 3'd0;
            byte_vld    <= 1'b0;
            rx_byte     <= 8'd0;
            rx_byte_cnt <= 10'd0;
            eop_ok      <= 1'b0;
            sym_err     <= 1'b0;
            hrst_det    <= 1'b0;
            crst_det    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ordset_vld <= 1'b0;
            byte_vld   <= 1'b0;
            eop_ok     <= 1'b0;
            sym_err    <= 1'b0;
            hrst_det   <= 1'b0;
            crst_det   <= 1'b0;
            if (!rx_en) begin
                state    <= ST_IDLE;
                hunt_sr  <= 20'd0;
                sym_sr   <= 5'd0;
                bit_cnt  <= 3'd0;
                nib_have <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_HUNT;
                        hunt_sr <= 20'd0;
                        busy    <= 1'b0;
                    end
                    ST_HUNT: begin
                        if (bit_vld) begin
                            if (hit) begin
                                // History is dropped after any match so one set fires once.
                                hunt_sr <= 20'd0;
                                if (hit_idx == 3'd3) begin
                                    hrst_det <= 1'b1;
                                end else if (hit_idx == 3'd4) begin
                                    crst_det <= 1'b1;
                                end else begin
                                    ordset_vld  <= 1'b1;
                                    ordset_type <= hit_idx;
                                    rx_byte_cnt <= 10'd0;
                                    state       <= ST_SYM;
                                    busy        <= 1'b1;
                                    bit_cnt     <= 3'd0;
                                    sym_sr      <= 5'd0;
                                    nib_have    <= 1'b0;
                                end
                            end else begin
                                hunt_sr <= hunt_next;
                            end
                        end
                    end
                    ST_SYM: begin
                        if (bit_vld) begin
                            if (bit_cnt == 3'd4) begin
                                bit_cnt <= 3'd0;
                                sym_sr  <= 5'd0;
                                if (dec[4] && !nib_have) begin
                                    nib_lo   <= dec[3:0];
                                    nib_have <= 1'b1;
                                end else if (dec[4] && (rx_byte_cnt != 10'(MAX_BYTES))) begin
                                    byte_vld <= 1'b1;
                                    rx_byte  <= {dec[3:0], nib_lo};
                                    nib_have <= 1'b0;
                                    if (rx_byte_cnt != 10'h3FF) rx_byte_cnt <= rx_byte_cnt + 10'd1;
                                end else begin
                                    if (sym_next == K_EOP && !nib_have) eop_ok <= 1'b1;
                                    else sym_err <= 1'b1;
                                    state    <= ST_HUNT;
                                    busy     <= 1'b0;
                                    hunt_sr  <= 20'd0;
                                    nib_have <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sym_sr  <= sym_next;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_ucpd_rx_sym_dec.sv
// Scoreboard bench for apb_ucpd_rx_sym_dec: a bit-stream reference model queues expected pulses.
module tb_apb_ucpd_rx_sym_dec;

    localparam int MAX_BYTES = 264;
    localparam int K_OS = 0, K_BYTE = 1, K_EOP = 2, K_ERR = 3, K_HRST = 4, K_CRST = 5;
    localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
    localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;

    logic       ic_clk = 1'b0;
    logic       ic_rst_n = 1'b0;
    logic       rx_en = 1'b0;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b0;
    logic [8:0] rx_ordset_en = 9'h000;
    logic       ordset_vld, byte_vld, eop_ok, sym_err, hrst_det, crst_det, busy;
    logic [2:0] ordset_type;
    logic [7:0] rx_byte;
    logic [9:0] rx_byte_cnt;

    apb_ucpd_rx_sym_dec #(.MAX_BYTES(MAX_BYTES)) dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .rx_en(rx_en), .bit_vld(bit_vld),
        .bit_in(bit_in), .rx_ordset_en(rx_ordset_en), .ordset_vld(ordset_vld),
        .ordset_type(ordset_type), .byte_vld(byte_vld), .rx_byte(rx_byte),
        .rx_byte_cnt(rx_byte_cnt), .eop_ok(eop_ok), .sym_err(sym_err),
        .hrst_det(hrst_det), .crst_det(crst_det), .busy(busy)
    );

    always #5 ic_clk = ~ic_clk;

    int cyc = 0;
    always @(posedge ic_clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

`ifdef UCPD_RX_KCODE_STRICT_EN
    int thr = 4;
`else
    int thr = 3;
`endif

    logic [4:0] data_code [16];
    logic [4:0] os_seq [7][4];

    // Reference model state
    int         m_mode = 0;   // 0 off, 1 hunting, 2 in frame
    bit         hist[$];
    logic [4:0] m_cur;
    int         m_curn;
    bit         m_nh;
    logic [3:0] m_nib;
    int         m_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input int val, input int cnt);
        exp_t e;
        e.kind = kind; e.val = val; e.cnt = cnt; e.cyc = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic model_to_hunt();
        m_mode = 1;
        hist.delete();
    endtask

    task automatic model_bit(input bit b);
        if (m_mode == 1) begin
            hist.push_back(b);
            if (hist.size() > 20) void'(hist.pop_front());
            for (int s = 0; s < 7; s++) begin
                int eq;
                if (!rx_ordset_en[s]) continue;
                eq = 0;
                for (int k = 0; k < 4; k++) begin
                    logic [4:0] w;
                    for (int j = 0; j < 5; j++) begin
                        int idx;
                        idx = hist.size() - 20 + 5 * k + j;
                        w[j] = (idx >= 0) ? hist[idx] : 1'b0;
                    end
                    if (w == os_seq[s][k]) eq++;
                end
                if (eq >= thr) begin
                    hist.delete();
                    if (s == 3) push_exp(K_HRST, 0, 0);
                    else if (s == 4) push_exp(K_CRST, 0, 0);
                    else begin
                        push_exp(K_OS, s, 0);
                        m_cnt = 0; m_mode = 2; m_curn = 0; m_nh = 0;
                    end
                    break;
                end
            end
        end else if (m_mode == 2) begin
            m_cur[m_curn] = b;
            m_curn++;
            if (m_curn == 5) begin
                int d;
                m_curn = 0;
                d = -1;
                for (int i = 0; i < 16; i++) if (data_code[i] == m_cur) d = i;
                if (d >= 0 && !m_nh) begin
                    m_nib = 4'(d); m_nh = 1;
                end else if (d >= 0) begin
                    if (m_cnt == MAX_BYTES) begin
                        push_exp(K_ERR, 0, 0); model_to_hunt();
                    end else begin
                        if (m_cnt < 1023) m_cnt++;
                        push_exp(K_BYTE, d * 16 + int'(m_nib), m_cnt);
                        m_nh = 0;
                    end
                end else if (m_cur == EOP && !m_nh) begin
                    push_exp(K_EOP, 0, m_cnt); model_to_hunt();
                end else begin
                    push_exp(K_ERR, 0, 0); model_to_hunt();
                end
            end
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge ic_clk);
        bit_vld = 1'b1;
        bit_in = b;
        if (rx_en) model_bit(b);
        @(negedge ic_clk);
        bit_vld = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge ic_clk);
    endtask

    task automatic send_sym(input logic [4:0] v);
        for (int j = 0; j < 5; j++) send_bit(v[j]);
    endtask

    task automatic send_os(input int s, input int corrupt);
        for (int k = 0; k < 4; k++) send_sym((k == corrupt) ? 5'b00000 : os_seq[s][k]);
    endtask

    task automatic send_byte(input logic [7:0] x);
        send_sym(data_code[x[3:0]]);
        send_sym(data_code[x[7:4]]);
    endtask

    task automatic preamble();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
    endtask

    task automatic check_busy(input string name);
        check(name, int'(busy), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic enable_rx();
        @(negedge ic_clk);
        rx_en = 1'b1;
        model_to_hunt();
        repeat (2) @(negedge ic_clk);
    endtask

    // Monitor: pops one expectation per observed pulse.
    initial begin
        forever begin
            @(negedge ic_clk);
            if (ic_rst_n) begin
                int n, k;
                exp_t e;
                n = int'(ordset_vld) + int'(byte_vld) + int'(eop_ok) + int'(sym_err)
                  + int'(hrst_det) + int'(crst_det);
                if (n > 1) check("one_pulse", n, 1);
                if (n >= 1) begin
                    k = ordset_vld ? K_OS : byte_vld ? K_BYTE : eop_ok ? K_EOP :
                        sym_err ? K_ERR : hrst_det ? K_HRST : K_CRST;
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse: got kind %0d expected none (t=%0t)", k, $time);
                    end else begin
                        e = sbq.pop_front();
                        check("pulse_kind", k, e.kind);
                        check("pulse_cycle", cyc, e.cyc);
                        if (k == e.kind) begin
                            if (k == K_OS) begin
                                check("ordset_type", int'(ordset_type), e.val);
                                check("cnt_on_sop", int'(rx_byte_cnt), 0);
                            end else if (k == K_BYTE) begin
                                check("rx_byte", int'(rx_byte), e.val);
                                check("byte_cnt", int'(rx_byte_cnt), e.cnt);
                            end else if (k == K_EOP) begin
                                check("cnt_at_eop", int'(rx_byte_cnt), e.cnt);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        data_code = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                      5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
        os_seq[0] = '{S1, S1, S1, S2};
        os_seq[1] = '{S1, S1, S3, S3};
        os_seq[2] = '{S1, S3, S1, S3};
        os_seq[3] = '{R1, R1, R1, R2};
        os_seq[4] = '{R1, S1, R1, S3};
        os_seq[5] = '{S1, R2, R2, S3};
        os_seq[6] = '{S1, R2, S3, S2};

        repeat (3) @(negedge ic_clk);
        check("rst_outputs", int'({ordset_vld, byte_vld, eop_ok, sym_err, hrst_det, crst_det, busy}), 0);
        check("rst_type", int'(ordset_type), 0);
        check("rst_byte", int'(rx_byte), 0);
        check("rst_cnt", int'(rx_byte_cnt), 0);
        ic_rst_n = 1'b1;

        // Basic frame
        rx_ordset_en = 9'h001;
        enable_rx();
        preamble();
        send_os(0, -1);
        check_busy("busy_after_sop");
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_sym(EOP);
        check_busy("busy_after_eop");
        check("cnt_held", int'(rx_byte_cnt), m_cnt);

        // Corrupted SOP symbol
        preamble();
        send_os(0, 2);
        check_busy("busy_corrupt_sop");
        send_byte(8'($urandom));
        send_sym(EOP);

        // Hard/Cable reset detection
        rx_ordset_en = 9'h008;
        preamble(); send_os(3, -1);
        check_busy("busy_hrst");
        rx_ordset_en = 9'h000;
        preamble(); send_os(3, -1);
        rx_ordset_en = 9'h010;
        preamble(); send_os(4, -1);

        // SOP' masked, then enabled
        rx_ordset_en = 9'h001;
        preamble(); send_os(1, -1);
        check_busy("busy_sop1_masked");
        rx_ordset_en = 9'h002;
        preamble(); send_os(1, -1);
        send_byte(8'($urandom)); send_sym(EOP);

        // Invalid symbol mid-frame, odd-nibble EOP
        rx_ordset_en = 9'h001;
        preamble(); send_os(0, -1);
        send_byte(8'h5A); send_sym(5'b00000);
        check_busy("busy_after_badsym");
        preamble(); send_os(0, -1);
        send_sym(data_code[7]); send_sym(EOP);

        // rx_en drop mid-symbol
        preamble(); send_os(0, -1);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        @(negedge ic_clk);
        rx_en = 1'b0;
        m_mode = 0;
        @(negedge ic_clk);
        check("busy_after_drop", int'(busy), 0);
        for (int i = 0; i < 25; i++) send_bit(1'($urandom));
        enable_rx();

        // Random frames
        for (int f = 0; f < 8; f++) begin
            int sel, nb;
            sel = $urandom_range(0, 4);
            sel = (sel < 3) ? sel : sel + 2;
            rx_ordset_en = 9'($urandom) | (9'h001 << sel);
            nb = $urandom_range(0, 4);
            preamble();
            send_os(sel, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
            for (int b = 0; b < nb; b++) send_byte(8'($urandom));
            send_sym(($urandom_range(0, 4) == 0) ? data_code[$urandom_range(0, 15)] : EOP);
            if ($urandom_range(0, 1) == 0) send_sym(EOP);
            check_busy("busy_rand_frame");
        end

        // Overflow
        rx_ordset_en = 9'h001;
        preamble(); send_os(0, -1);
        for (int b = 0; b < MAX_BYTES + 1; b++) send_byte(8'($urandom));
        check_busy("busy_after_ovf");
        check("cnt_after_ovf", int'(rx_byte_cnt), MAX_BYTES);

        repeat (10) @(negedge ic_clk);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
